commit_trace_buffer: RTL and testbench

Parametrised retire-trace buffer that sits between the CPU core's retire point and the simulation checker. It accepts one retired-instruction record per cycle (pc, instr, rd/rs/rt values) over a valid/ready handshake and queues it in a FIFO. The checker drains the FIFO at its own pace. The block also detects the end-of-program condition (exit-syscall instruction with the exit code in v0), counts retired instructions, and flags a no-retire watchdog timeout, so the checker no longer has to lock-step the core.

---
 rtl/commit_trace_buffer.sv | 118 +++++++++++
 tb/tb_commit_trace_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Retire-trace FIFO (FWFT) between core retire and checker, plus end-of-program detect, retire count and idle watchdog.
// Accept-to-out_valid is 1 cycle; ret_ready drops when full (or full records are dropped) and closes for good after done.
module commit_trace_buffer #(
  parameter int                DATA_W        = 32,
  parameter int                DEPTH         = 16,
  parameter int                STALL_ON_FULL = 1,
  parameter logic [DATA_W-1:0] END_INSTR     = DATA_W'(32'h0000_000c),
  parameter logic [DATA_W-1:0] END_CODE      = DATA_W'(32'h0000_000a),
  parameter int                TIMEOUT       = 0,
  parameter int                CNT_W         = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ret_valid,
  output logic                       ret_ready,
  input  logic [DATA_W-1:0]          ret_pc,
  input  logic [DATA_W-1:0]          ret_instr,
  input  logic [DATA_W-1:0]          ret_rd,
  input  logic [DATA_W-1:0]          ret_rs,
  input  logic [DATA_W-1:0]          ret_rt,
  input  logic [DATA_W-1:0]          ret_v0,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instr,
  output logic [DATA_W-1:0]          out_rd,
  output logic [DATA_W-1:0]          out_rs,
  output logic [DATA_W-1:0]          out_rt,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           retired,
  output logic                       overflow,
  output logic                       done,
  output logic                       timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = 5 * DATA_W;
  // Timeout fires on the edge where idle steps from TIMEOUT-1 to TIMEOUT.
  localparam logic [CNT_W-1:0] LP_IDLE_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [RW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_idle;
  logic             r_overflow;
  logic             r_done;
  logic             r_timeout;

  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_end;
  logic             w_idle_tick;
  logic [RW-1:0]    w_head;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign ret_ready   = (STALL_ON_FULL != 0) ? (!w_full && !r_done) : !r_done;
  assign out_valid   = !w_empty;
  assign w_accept    = ret_valid && ret_ready;
  assign w_pop       = out_valid && out_ready;
  // A full FIFO can still take a record when the head leaves on the same edge.
  assign w_push      = w_accept && (!w_full || w_pop);
  assign w_drop      = w_accept && !w_push;
  assign w_end       = w_accept && (ret_instr == END_INSTR) && (ret_v0 == END_CODE);
  assign w_idle_tick = (TIMEOUT > 0) && !w_accept && !r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_retired  <= '0;
      r_idle     <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && (r_retired != '1)) r_retired <= r_retired + CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
      if (w_end)  r_done     <= 1'b1;
      if (w_accept)
        r_idle <= '0;
      else if (w_idle_tick && (r_idle != '1))
        r_idle <= r_idle + CNT_W'(1);
      if (w_idle_tick && (r_idle == LP_IDLE_LAST)) r_timeout <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {ret_pc, ret_instr, ret_rd, ret_rs, ret_rt};
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];
  assign {out_pc, out_instr, out_rd, out_rs, out_rt} = w_head;

  assign count    = r_count;
  assign retired  = r_retired;
  assign overflow = r_overflow;
  assign done     = r_done;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: default, drop-mode (DEPTH=4) and watchdog (TIMEOUT=8) instances share stimulus.
module tb_commit_trace_buffer;
  logic        clk;
  logic        rst_n;
  logic        ret_valid;
  logic        out_ready;
  logic [31:0] ret_pc, ret_instr, ret_rd, ret_rs, ret_rt, ret_v0;

  logic        a_ret_ready, a_out_valid, a_overflow, a_done, a_timeout;
  logic [31:0] a_out_pc, a_out_instr, a_out_rd, a_out_rs, a_out_rt, a_retired;
  logic [4:0]  a_count;

  logic        b_ret_ready, b_out_valid, b_overflow, b_done, b_timeout;
  logic [31:0] b_out_pc, b_out_instr, b_out_rd, b_out_rs, b_out_rt, b_retired;
  logic [2:0]  b_count;

  logic        c_ret_ready, c_out_valid, c_overflow, c_done, c_timeout;
  logic [31:0] c_out_pc, c_out_instr, c_out_rd, c_out_rs, c_out_rt, c_retired;
  logic [4:0]  c_count;

  int n_checks = 0;
  int n_fail   = 0;

  commit_trace_buffer u_a (
    .clk(clk), .reset(rst_n), .ret_valid(ret_valid), .ret_ready(a_ret_ready),
    .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_rd(ret_rd), .ret_rs(ret_rs), .ret_rt(ret_rt),
    .ret_v0(ret_v0), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_instr(a_out_instr), .out_rd(a_out_rd), .out_rs(a_out_rs), .out_rt(a_out_rt),
    .count(a_count), .retired(a_retired), .overflow(a_overflow), .done(a_done), .timeout(a_timeout)
  );

  commit_trace_buffer #(.DEPTH(4), .STALL_ON_FULL(0)) u_b (
    .clk(clk), .reset(rst_n), .ret_valid(ret_valid), .ret_ready(b_ret_ready),
    .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_rd(ret_rd), .ret_rs(ret_rs), .ret_rt(ret_rt),
    .ret_v0(ret_v0), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_instr(b_out_instr), .out_rd(b_out_rd), .out_rs(b_out_rs), .out_rt(b_out_rt),
    .count(b_count), .retired(b_retired), .overflow(b_overflow), .done(b_done), .timeout(b_timeout)
  );

  commit_trace_buffer #(.TIMEOUT(8)) u_c (
    .clk(clk), .reset(rst_n), .ret_valid(ret_valid), .ret_ready(c_ret_ready),
    .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_rd(ret_rd), .ret_rs(ret_rs), .ret_rt(ret_rt),
    .ret_v0(ret_v0), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_pc(c_out_pc), .out_instr(c_out_instr), .out_rd(c_out_rd), .out_rs(c_out_rs), .out_rt(c_out_rt),
    .count(c_count), .retired(c_retired), .overflow(c_overflow), .done(c_done), .timeout(c_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] v0);
    ret_pc    = pc;
    ret_instr = instr;
    ret_rd    = pc + 32'h100;
    ret_rs    = pc + 32'h200;
    ret_rt    = pc + 32'h300;
    ret_v0    = v0;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    ret_valid = 1'b0;
    out_ready = 1'b0;
    set_rec(32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ret_valid = 1'b0;
    out_ready = 1'b0;
    set_rec(32'h0, 32'h0, 32'h0);
    step();
    n_checks++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", a_count); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_ret_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ret_ready: got %b expected 1", a_ret_ready); end
    n_checks++; if (a_retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", a_retired); end
    n_checks++; if ({a_overflow, a_done, a_timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {a_overflow, a_done, a_timeout}); end
    n_checks++; if ({b_ret_ready, c_ret_ready, c_timeout} !== 3'b110) begin n_fail++; $display("FAIL reset_bc: got %b expected 110", {b_ret_ready, c_ret_ready, c_timeout}); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      set_rec(32'(i * 4), 32'h1000 + 32'(i), 32'h0);
      ret_valid = 1'b1;
      step();
      n_checks++; if (a_count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, a_count, i + 1); end
    end
    ret_valid = 1'b0;
    n_checks++; if (a_ret_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b expected 0", a_ret_ready); end
    n_checks++; if (a_retired !== 32'd16) begin n_fail++; $display("FAIL fill_retired: got %0d expected 16", a_retired); end
    step();
    n_checks++; if (a_count !== 5'd16) begin n_fail++; $display("FAIL fill_hold_count: got %0d expected 16", a_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, a_out_valid); end
      n_checks++; if (a_out_pc !== 32'(i * 4) || a_out_instr !== 32'h1000 + 32'(i)) begin
        n_fail++; $display("FAIL drain_pc_instr[%0d]: got %h/%h expected %h/%h", i, a_out_pc, a_out_instr, 32'(i * 4), 32'h1000 + 32'(i));
      end
      n_checks++; if ({a_out_rd, a_out_rs, a_out_rt} !== {32'(i * 4) + 32'h100, 32'(i * 4) + 32'h200, 32'(i * 4) + 32'h300}) begin
        n_fail++; $display("FAIL drain_regs[%0d]: got %h %h %h", i, a_out_rd, a_out_rs, a_out_rt);
      end
      step();
      if (i == 0) begin
        n_checks++; if (a_ret_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_pop: got %b expected 1", a_ret_ready); end
      end
    end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", a_count); end
    n_checks++; if (a_retired !== 32'd16) begin n_fail++; $display("FAIL drain_retired: got %0d expected 16", a_retired); end
  endtask

  task automatic test_streaming();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      set_rec(32'h4000 + 32'(k), 32'h13, 32'h0);
      ret_valid = 1'b1;
      step();
      n_checks++; if (a_count !== 5'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, a_count); end
      n_checks++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h4000 + 32'(k)) begin
        n_fail++; $display("FAIL stream_pc[%0d]: got %b/%h expected 1/%h", k, a_out_valid, a_out_pc, 32'h4000 + 32'(k));
      end
    end
    ret_valid = 1'b0;
    step();
    n_checks++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL stream_final_count: got %0d expected 0", a_count); end
    n_checks++; if (a_retired !== 32'd100) begin n_fail++; $display("FAIL stream_retired: got %0d expected 100", a_retired); end
  endtask

  task automatic test_drop_mode();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_rec(32'(i * 4), 32'h2000 + 32'(i), 32'h0);
      ret_valid = 1'b1;
      step();
      if (i == 3) begin
        n_checks++; if (b_overflow !== 1'b0) begin n_fail++; $display("FAIL drop_no_ovf_at_4: got %b expected 0", b_overflow); end
      end
    end
    ret_valid = 1'b0;
    n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("FAIL drop_count: got %0d expected 4", b_count); end
    n_checks++; if (b_overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %b expected 1", b_overflow); end
    n_checks++; if (b_retired !== 32'd6) begin n_fail++; $display("FAIL drop_retired: got %0d expected 6", b_retired); end
    n_checks++; if (b_ret_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %b expected 1", b_ret_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (b_out_valid !== 1'b1 || b_out_pc !== 32'(i * 4)) begin
        n_fail++; $display("FAIL drop_order[%0d]: got %b/%h expected 1/%h", i, b_out_valid, b_out_pc, 32'(i * 4));
      end
      step();
    end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_drained: got %b expected 0", b_out_valid); end

    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_rec(32'(i * 4), 32'h2000 + 32'(i), 32'h0);
      out_ready = (i == 4);
      ret_valid = 1'b1;
      step();
      if (i == 4) begin
        n_checks++; if (b_overflow !== 1'b0) begin n_fail++; $display("FAIL drop_pop_ovf: got %b expected 0", b_overflow); end
        n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("FAIL drop_pop_count: got %0d expected 4", b_count); end
      end
    end
    ret_valid = 1'b0;
    n_checks++; if (b_overflow !== 1'b1) begin n_fail++; $display("FAIL drop_sixth_ovf: got %b expected 1", b_overflow); end
    n_checks++; if (b_retired !== 32'd6) begin n_fail++; $display("FAIL drop2_retired: got %0d expected 6", b_retired); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (b_out_pc !== 32'((i + 1) * 4)) begin
        n_fail++; $display("FAIL drop2_order[%0d]: got %h expected %h", i, b_out_pc, 32'((i + 1) * 4));
      end
      step();
    end
  endtask

  task automatic test_end_detect();
    apply_reset();
    set_rec(32'h0, 32'h20, 32'ha);
    ret_valid = 1'b1;
    step();
    set_rec(32'h4, 32'hc, 32'h9);
    step();
    n_checks++; if (a_done !== 1'b0 || a_ret_ready !== 1'b1) begin n_fail++; $display("FAIL end_wrong_v0: got done=%b ready=%b expected 0/1", a_done, a_ret_ready); end
    set_rec(32'h8, 32'hc, 32'ha);
    step();
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL end_done: got %b expected 1", a_done); end
    n_checks++; if (a_ret_ready !== 1'b0) begin n_fail++; $display("FAIL end_ready: got %b expected 0", a_ret_ready); end
    n_checks++; if (a_count !== 5'd3) begin n_fail++; $display("FAIL end_count: got %0d expected 3", a_count); end
    set_rec(32'hc, 32'h1, 32'h0);
    step();
    n_checks++; if (a_count !== 5'd3 || a_retired !== 32'd3) begin n_fail++; $display("FAIL end_blocked: got count=%0d retired=%0d expected 3/3", a_count, a_retired); end
    ret_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'(i * 4)) begin
        n_fail++; $display("FAIL end_drain[%0d]: got %b/%h expected 1/%h", i, a_out_valid, a_out_pc, 32'(i * 4));
      end
      step();
    end
    n_checks++; if (a_out_valid !== 1'b0 || a_done !== 1'b1) begin n_fail++; $display("FAIL end_after_drain: got valid=%b done=%b expected 0/1", a_out_valid, a_done); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    out_ready = 1'b1;
    set_rec(32'h0, 32'h1, 32'h0);
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      n_checks++; if (c_timeout !== ((j == 8) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL wd_idle[%0d]: got %b expected %b", j, c_timeout, (j == 8)); end
    end

    apply_reset();
    out_ready = 1'b1;
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    repeat (7) step();
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      n_checks++; if (c_timeout !== ((j == 8) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL wd_rearm[%0d]: got %b expected %b", j, c_timeout, (j == 8)); end
    end
    n_checks++; if (c_ret_ready !== 1'b1) begin n_fail++; $display("FAIL wd_ready: got %b expected 1", c_ret_ready); end
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    n_checks++; if (c_retired !== 32'd3 || c_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got retired=%0d timeout=%b expected 3/1", c_retired, c_timeout); end

    apply_reset();
    out_ready = 1'b1;
    set_rec(32'h0, 32'hc, 32'ha);
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    repeat (12) step();
    n_checks++; if (c_done !== 1'b1 || c_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_after_done: got done=%b timeout=%b expected 1/0", c_done, c_timeout); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_rec(32'(i * 4), (i == 4) ? 32'hc : 32'h1, 32'ha);
      ret_valid = 1'b1;
      step();
    end
    ret_valid = 1'b0;
    n_checks++; if (a_count !== 5'd5 || a_done !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got count=%0d done=%b expected 5/1", a_count, a_done); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_count !== 5'd0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_fifo: got count=%0d valid=%b expected 0/0", a_count, a_out_valid); end
    n_checks++; if (a_done !== 1'b0 || a_retired !== 32'd0) begin n_fail++; $display("FAIL mid_async_state: got done=%b retired=%0d expected 0/0", a_done, a_retired); end
    n_checks++; if (a_ret_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_ready: got %b expected 1", a_ret_ready); end
    step();
    step();
    rst_n = 1'b1;
    set_rec(32'h77, 32'h1, 32'h0);
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    n_checks++; if (a_count !== 5'd1 || a_out_valid !== 1'b1 || a_out_pc !== 32'h77) begin
      n_fail++; $display("FAIL mid_first_push: got count=%0d valid=%b pc=%h expected 1/1/77", a_count, a_out_valid, a_out_pc);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_drop_mode();
    test_end_detect();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
